// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 4-digit BCD scanner with double-buffered load, leading-zero suppression and anti-ghost blanking
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lz_suppress,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  digit_num,
  output logic [3:0]  anode,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] slot, slot_n;
  logic [15:0] active, active_n, shadow;
  logic pending, pending_n, accept, commit, supp_n, z3, z2, z1;
  logic [3:0] nib_n;
  assign digit_sel = slot;
  // slot sequencing: blank window, then drive window, abandon the slot when disabled
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    slot_n = slot;
    if (!enable) begin
      state_n = IDLE;
      cnt_n = '0;
      slot_n = '0;
    end else if (state == IDLE) begin
      state_n = BLANK;
      cnt_n = '0;
      slot_n = '0;
    end else if (state == BLANK) begin
      cnt_n = cnt + CW'(1);
      state_n = (cnt == CW'(BLANK_CYCLES - 1)) ? DRIVE : BLANK;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      state_n = BLANK;
      cnt_n = '0;
      slot_n = slot + 2'd1;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
  // handshake, frame-boundary commit and next-cycle output values
  always_comb begin
    accept = load_valid && !pending;
    commit = pending && (frame_done || state == IDLE);
    active_n = commit ? shadow : active;
    pending_n = commit ? 1'b0 : (accept || pending);
    nib_n = active_n[4*slot_n +: 4];
    z3 = active_n[15:12] == 4'd0;
    z2 = z3 && active_n[11:8] == 4'd0;
    z1 = z2 && active_n[7:4] == 4'd0;
    supp_n = lz_suppress && (slot_n == 2'd3 ? z3 : slot_n == 2'd2 ? z2 : slot_n == 2'd1 ? z1 : 1'b0);
  end
  // all state and outputs registered so nothing on the pins depends combinationally on inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      slot <= '0;
      active <= '0;
      shadow <= '0;
      pending <= 1'b0;
      load_ready <= 1'b1;
      digit_num <= '0;
      anode <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      slot <= slot_n;
      active <= active_n;
      if (accept) shadow <= load_data;
      pending <= pending_n;
      load_ready <= !pending_n;
      digit_num <= nib_n;
      anode <= (state_n == DRIVE && !supp_n) ? ~(4'b0001 << slot_n) : 4'hF;
      frame_done <= state_n == DRIVE && slot_n == 2'd3 && cnt_n == CW'(REFRESH_DIV - 1);
    end
  end
endmodule
